// File: rtl/mem_sequencer_if.sv
// Request / response / RAM bus bundle for mem_sequencer.
// The master modport is the requester plus RAM side (the environment);
// the slave modport is the sequencer itself.
interface mem_sequencer_if #(
  parameter int addr_size = 4,
  parameter int cell_size = 16
);
  // Request channel
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [addr_size-1:0] req_addr;
  logic [addr_size-1:0] req_len;
  logic [cell_size-1:0] req_wdata;
  // Response channel
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [cell_size-1:0] rsp_data;
  logic                 rsp_last;
  // Status
  logic                 busy;
  // RAM port (1-cycle registered read)
  logic [addr_size-1:0] ram_ra;
  logic [addr_size-1:0] ram_wa;
  logic [cell_size-1:0] ram_data;
  logic                 ram_we;
  logic [cell_size-1:0] ram_result;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata,
    output rsp_ready, ram_result,
    input  req_ready, rsp_valid, rsp_data, rsp_last, busy,
    input  ram_ra, ram_wa, ram_data, ram_we
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata,
    input  rsp_ready, ram_result,
    output req_ready, rsp_valid, rsp_data, rsp_last, busy,
    output ram_ra, ram_wa, ram_data, ram_we
  );
endinterface

// File: rtl/mem_sequencer.sv
// Burst sequencer in front of a single-port-style RAM: fills a run of
// addresses with one value, or reads a run back as a beat stream.
//
// Handshake rule (both channels): a transfer happens at a posedge where
// valid and ready are both high; valid/ready never depend combinationally
// on the other side's ready/valid inside this block.
module mem_sequencer #(
  parameter int addr_size = 4,
  parameter int cell_size = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_sequencer_if.slave       bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_READ = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [addr_size-1:0] ADDR_ONE = {{(addr_size-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [addr_size-1:0] r_cur_addr;
  logic [addr_size-1:0] r_cnt;
  logic [cell_size-1:0] r_wdata_q;
  logic                 r_req_ready;
  logic                 r_busy;
  logic                 r_ram_we;
  logic                 r_rsp_valid;
  logic                 r_rsp_last;

  logic                 w_cnt_zero;
  logic [addr_size-1:0] w_addr_next;
  logic [addr_size-1:0] w_cnt_next;

  // Address and count arithmetic wraps naturally at the register width.
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_addr_next = r_cur_addr + ADDR_ONE;
  assign w_cnt_next  = r_cnt - ADDR_ONE;

  // Single FSM: state, burst registers and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_cnt       <= '0;
      r_wdata_q   <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_ram_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_cur_addr  <= bus.req_addr;
            r_cnt       <= bus.req_len;
            r_wdata_q   <= bus.req_wdata;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.req_write) begin
              r_state  <= S_FILL;
              r_ram_we <= 1'b1;
            end else begin
              r_state  <= S_READ;
            end
          end
        end
        S_FILL: begin
          if (w_cnt_zero) begin
            r_state     <= S_IDLE;
            r_ram_we    <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cur_addr <= w_addr_next;
            r_cnt      <= w_cnt_next;
          end
        end
        S_READ: begin
          // ram_ra has been presented for one edge; data is valid next cycle.
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_last  <= w_cnt_zero;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            if (w_cnt_zero) begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_state    <= S_READ;
              r_cur_addr <= w_addr_next;
              r_cnt      <= w_cnt_next;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_ram_we    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_last  <= 1'b0;
        end
      endcase
    end
  end

  // Read data passes straight through from the RAM but only while a beat
  // is offered; the address is held in RESP so the data stays stable.
  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_last  = r_rsp_last;
  assign bus.rsp_data  = r_rsp_valid ? bus.ram_result : '0;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_data  = r_ram_we ? r_wdata_q : '0;
  assign bus.ram_ra    = r_cur_addr;
  assign bus.ram_wa    = r_cur_addr;
  assign o_dbg_state   = r_state;

endmodule
